// File: rtl/life_engine_if.sv
// Control and lookup bundle between the life engine and its driver/display side.
// Latency: none, wires only.
// Backpressure: none; pulses are accepted or dropped by the engine.
interface life_engine_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  mode_i;
    logic                  step_tick_i;
    logic                  toggle_i;
    logic                  clear_i;
    logic [ADDR_WIDTH-1:0] cur_x_i;
    logic [ADDR_WIDTH-1:0] cur_y_i;
    logic [ADDR_WIDTH-1:0] rd_x_i;
    logic [ADDR_WIDTH-1:0] rd_y_i;
    logic                  rd_state_o;
    logic                  busy_o;
    logic [15:0]           generation_o;

    modport master (
        output mode_i, step_tick_i, toggle_i, clear_i,
        output cur_x_i, cur_y_i, rd_x_i, rd_y_i,
        input  rd_state_o, busy_o, generation_o
    );

    modport slave (
        input  mode_i, step_tick_i, toggle_i, clear_i,
        input  cur_x_i, cur_y_i, rd_x_i, rd_y_i,
        output rd_state_o, busy_o, generation_o
    );
endinterface

// File: rtl/life_engine.sv
// Life cell store: combinational cell lookup, cursor toggles, one-cell-per-cycle generation sweep.
// Latency: lookup 0 cycles; toggle 1 cycle; step W*H+1 cycles to new map and generation count.
// Backpressure: none; step/toggle pulses arriving while busy are dropped, clear always wins.
module life_engine #(
    parameter int   MAP_WIDTH  = 8,
    parameter int   MAP_HEIGHT = 8,
    parameter logic MODE_EDIT  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    life_engine_if.slave  bus
);
    localparam int CELLS = MAP_WIDTH * MAP_HEIGHT;
    localparam int IW    = $clog2(CELLS);
    localparam int XW    = $clog2(MAP_WIDTH);
    localparam int YW    = $clog2(MAP_HEIGHT);

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_COMMIT} state_t;

    state_t           state_q, state_d;
    logic [CELLS-1:0] cur_map_q, cur_map_d;
    logic [CELLS-1:0] nxt_map_q, nxt_map_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [15:0]      gen_q, gen_d;

    logic             step_ok, tog_ok, sweep_last;
    logic             tog_in_range, rd_in_range;
    logic [IW-1:0]    tog_idx, rd_idx;
    logic [XW-1:0]    x_l, x_r;
    logic [YW-1:0]    y_u, y_dn;
    logic [3:0]       nbr_cnt;
    logic             self_alive, nxt_cell;

    // Bit of a map at (cx, cy); callers only pass in-range coordinates.
    function automatic logic cell_at(input logic [CELLS-1:0] m,
                                     input logic [XW-1:0] cx,
                                     input logic [YW-1:0] cy);
        logic [IW-1:0] i;
        i = IW'(int'(cy) * MAP_WIDTH + int'(cx));
        return m[i];
    endfunction

    assign tog_in_range = (int'(bus.cur_x_i) < MAP_WIDTH) && (int'(bus.cur_y_i) < MAP_HEIGHT);
    assign rd_in_range  = (int'(bus.rd_x_i) < MAP_WIDTH) && (int'(bus.rd_y_i) < MAP_HEIGHT);
    assign tog_idx      = IW'(int'(bus.cur_y_i) * MAP_WIDTH + int'(bus.cur_x_i));
    assign rd_idx       = IW'(int'(bus.rd_y_i) * MAP_WIDTH + int'(bus.rd_x_i));

    // Step only in run mode, toggle only in edit mode, and neither while a sweep is in flight.
    assign step_ok    = (state_q == ST_IDLE) && bus.step_tick_i && (bus.mode_i != MODE_EDIT);
    assign tog_ok     = (state_q == ST_IDLE) && bus.toggle_i && (bus.mode_i == MODE_EDIT) && tog_in_range;
    assign sweep_last = (idx_q == IW'(CELLS - 1));

    // Toroidal neighbour coordinates around the sweep position.
    always_comb begin
        x_l  = (x_q == '0) ? XW'(MAP_WIDTH - 1) : x_q - 1'b1;
        x_r  = (x_q == XW'(MAP_WIDTH - 1)) ? '0 : x_q + 1'b1;
        y_u  = (y_q == '0) ? YW'(MAP_HEIGHT - 1) : y_q - 1'b1;
        y_dn = (y_q == YW'(MAP_HEIGHT - 1)) ? '0 : y_q + 1'b1;
    end

    // Neighbour count and next-generation rule for the cell under the sweep.
    always_comb begin
        nbr_cnt = 4'(cell_at(cur_map_q, x_l, y_u))  + 4'(cell_at(cur_map_q, x_q, y_u))
                + 4'(cell_at(cur_map_q, x_r, y_u))  + 4'(cell_at(cur_map_q, x_l, y_q))
                + 4'(cell_at(cur_map_q, x_r, y_q))  + 4'(cell_at(cur_map_q, x_l, y_dn))
                + 4'(cell_at(cur_map_q, x_q, y_dn)) + 4'(cell_at(cur_map_q, x_r, y_dn));
        self_alive = cur_map_q[idx_q];
        nxt_cell   = (nbr_cnt == 4'd3) | (self_alive & (nbr_cnt == 4'd2));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state; clear aborts from anywhere.
    always_comb begin
        state_d = state_q;
        if (bus.clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (step_ok) state_d = ST_SWEEP;
                ST_SWEEP:  if (sweep_last) state_d = ST_COMMIT;
                ST_COMMIT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs; the lookup path sees only the committed map.
    always_comb begin
        bus.busy_o       = (state_q != ST_IDLE);
        bus.generation_o = gen_q;
        bus.rd_state_o   = rd_in_range ? cur_map_q[rd_idx] : 1'b0;
    end

    // Datapath next state: toggles, sweep writes into the shadow map, commit.
    always_comb begin
        cur_map_d = cur_map_q;
        nxt_map_d = nxt_map_q;
        idx_d     = idx_q;
        x_d       = x_q;
        y_d       = y_q;
        gen_d     = gen_q;
        if (bus.clear_i) begin
            cur_map_d = '0;
            nxt_map_d = '0;
            gen_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (step_ok) begin
                        idx_d = '0;
                        x_d   = '0;
                        y_d   = '0;
                    end
                    if (tog_ok) cur_map_d[tog_idx] = ~cur_map_q[tog_idx];
                end
                ST_SWEEP: begin
                    nxt_map_d[idx_q] = nxt_cell;
                    idx_d = idx_q + 1'b1;
                    if (x_q == XW'(MAP_WIDTH - 1)) begin
                        x_d = '0;
                        y_d = (y_q == YW'(MAP_HEIGHT - 1)) ? '0 : y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    cur_map_d = nxt_map_q;
                    gen_d     = gen_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_map_q <= '0;
            nxt_map_q <= '0;
            idx_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            gen_q     <= '0;
        end else begin
            cur_map_q <= cur_map_d;
            nxt_map_q <= nxt_map_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            y_q       <= y_d;
            gen_q     <= gen_d;
        end
    end
endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: reference life model feeds a scoreboard of expected maps/generations.
// Latency: checks step completion by counting busy cycles after the accepting edge.
// Backpressure: none; every wait on the DUT is bounded.
module tb_life_engine;
    localparam int W     = 8;
    localparam int H     = 8;
    localparam int LIMIT = 300;

    typedef struct {
        logic [63:0] map;
        logic [15:0] gen;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [63:0] mdl_map;
    logic [15:0] mdl_gen;
    exp_t        sb_q[$];

    life_engine_if #(.ADDR_WIDTH(8)) bus ();

    life_engine #(.MAP_WIDTH(W), .MAP_HEIGHT(H), .MODE_EDIT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] ci(input int x, input int y);
        return 6'(y * W + x);
    endfunction

    // Reference generation step computed directly from the life rules on a torus.
    function automatic logic [63:0] life_next(input logic [63:0] m);
        logic [63:0] r;
        int          n;
        r = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dx != 0 || dy != 0)
                            n += int'(m[ci((x + dx + W) % W, (y + dy + H) % H)]);
                r[ci(x, y)] = (n == 3) || (m[ci(x, y)] && n == 2);
            end
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_map(output logic [63:0] m);
        m = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                bus.rd_x_i = 8'(x);
                bus.rd_y_i = 8'(y);
                #1;
                m[ci(x, y)] = bus.rd_state_o;
            end
        end
    endtask

    task automatic read_cell(input int x, input int y, output logic v);
        bus.rd_x_i = 8'(x);
        bus.rd_y_i = 8'(y);
        #1;
        v = bus.rd_state_o;
    endtask

    task automatic pulse_toggle(input int x, input int y);
        logic v;
        @(negedge clk);
        bus.mode_i   = 1'b1;
        bus.cur_x_i  = 8'(x);
        bus.cur_y_i  = 8'(y);
        bus.toggle_i = 1'b1;
        @(negedge clk);
        bus.toggle_i = 1'b0;
        if (x < W && y < H) begin
            mdl_map[ci(x, y)] = ~mdl_map[ci(x, y)];
            read_cell(x, y, v);
            check_eq("toggle_vis", 64'(v), 64'(mdl_map[ci(x, y)]));
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        mdl_map = '0;
        mdl_gen = '0;
    endtask

    // Leaves the bench at the falling edge right after the accepting edge.
    task automatic start_step();
        @(negedge clk);
        bus.mode_i      = 1'b0;
        bus.step_tick_i = 1'b1;
        @(negedge clk);
        bus.step_tick_i = 1'b0;
    endtask

    task automatic push_expected();
        exp_t e;
        e.map = life_next(mdl_map);
        e.gen = mdl_gen + 16'd1;
        sb_q.push_back(e);
        mdl_map = e.map;
        mdl_gen = e.gen;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (bus.busy_o === 1'b1 && cnt < LIMIT) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic collect_result();
        exp_t        e;
        logic [63:0] m;
        e = sb_q.pop_front();
        read_map(m);
        check_eq("map", m, e.map);
        check_eq("generation", 64'(bus.generation_o), 64'(e.gen));
    endtask

    task automatic do_step(input bit chk_lat);
        int cnt;
        start_step();
        push_expected();
        check_eq("busy_rise", 64'(bus.busy_o), 64'd1);
        wait_idle(cnt);
        check_eq("sweep_done", 64'(bus.busy_o), 64'd0);
        if (chk_lat) check_eq("busy_cycles", 64'(cnt), 64'd65);
        collect_result();
    endtask

    initial begin
        logic [63:0] m;
        logic [63:0] vert, horiz, glider;
        logic        v;
        int          cnt;

        n_cmp = 0;
        n_err = 0;
        mdl_map = '0;
        mdl_gen = '0;
        bus.mode_i = 1'b0;
        bus.step_tick_i = 1'b0;
        bus.toggle_i = 1'b0;
        bus.clear_i = 1'b0;
        bus.cur_x_i = '0;
        bus.cur_y_i = '0;
        bus.rd_x_i = '0;
        bus.rd_y_i = '0;
        vert   = '0;
        horiz  = '0;
        glider = '0;
        vert[ci(3, 2)] = 1'b1; vert[ci(3, 3)] = 1'b1; vert[ci(3, 4)] = 1'b1;
        horiz[ci(2, 3)] = 1'b1; horiz[ci(3, 3)] = 1'b1; horiz[ci(4, 3)] = 1'b1;
        glider[ci(7, 6)] = 1'b1; glider[ci(0, 7)] = 1'b1; glider[ci(6, 0)] = 1'b1;
        glider[ci(7, 0)] = 1'b1; glider[ci(0, 0)] = 1'b1;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_map(m);
        check_eq("rst_map", m, 64'd0);
        read_cell(8, 0, v);
        check_eq("rst_oob_x", 64'(v), 64'd0);
        read_cell(0, 200, v);
        check_eq("rst_oob_y", 64'(v), 64'd0);
        check_eq("rst_busy", 64'(bus.busy_o), 64'd0);
        check_eq("rst_gen", 64'(bus.generation_o), 64'd0);

        // Out-of-range lookup must not alias onto (0,1).
        pulse_toggle(0, 1);
        read_cell(8, 0, v);
        check_eq("oob_alias", 64'(v), 64'd0);
        pulse_toggle(0, 1);

        // Ignored toggles: out-of-range cursor, and run mode.
        pulse_toggle(8, 0);
        @(negedge clk);
        bus.mode_i = 1'b0; bus.cur_x_i = 8'd5; bus.cur_y_i = 8'd5; bus.toggle_i = 1'b1;
        @(negedge clk);
        bus.toggle_i = 1'b0;
        read_cell(5, 5, v);
        check_eq("run_toggle", 64'(v), 64'd0);

        // Blinker.
        pulse_toggle(3, 2);
        pulse_toggle(3, 3);
        pulse_toggle(3, 4);
        read_map(m);
        check_eq("blinker_load", m, vert);
        do_step(1'b1);
        read_map(m);
        check_eq("blinker_h", m, horiz);
        do_step(1'b1);
        read_map(m);
        check_eq("blinker_v", m, vert);

        // step_tick and toggle during a sweep are dropped; mode flips mid-sweep.
        start_step();
        push_expected();
        repeat (10) @(negedge clk);
        bus.mode_i = 1'b0; bus.step_tick_i = 1'b1;
        @(negedge clk);
        bus.step_tick_i = 1'b0;
        bus.mode_i = 1'b1; bus.cur_x_i = 8'd0; bus.cur_y_i = 8'd0; bus.toggle_i = 1'b1;
        @(negedge clk);
        bus.toggle_i = 1'b0;
        wait_idle(cnt);
        check_eq("busy_sweep_ign", 64'(bus.busy_o), 64'd0);
        collect_result();
        repeat (3) @(negedge clk);
        check_eq("no_queued_step", 64'(bus.busy_o), 64'd0);
        read_map(m);
        check_eq("ign_map_horiz", m, horiz);

        // clear mid-sweep.
        start_step();
        repeat (29) @(negedge clk);
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        mdl_map = '0;
        mdl_gen = '0;
        check_eq("clear_busy", 64'(bus.busy_o), 64'd0);
        read_map(m);
        check_eq("clear_map", m, 64'd0);
        check_eq("clear_gen", 64'(bus.generation_o), 64'd0);
        do_step(1'b1);

        // Glider wraps the torus in 32 generations.
        pulse_clear();
        pulse_toggle(7, 6);
        pulse_toggle(0, 7);
        pulse_toggle(6, 0);
        pulse_toggle(7, 0);
        pulse_toggle(0, 0);
        for (int s = 0; s < 32; s++) do_step(s == 0);
        read_map(m);
        check_eq("glider_wrap", m, glider);
        check_eq("glider_gen", 64'(bus.generation_o), 64'd32);

        // Asynchronous reset between edges mid-sweep.
        start_step();
        repeat (20) @(negedge clk);
        read_cell(0, 0, v);
        check_eq("pre_rst_cell", 64'(v), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_busy", 64'(bus.busy_o), 64'd0);
        check_eq("arst_gen", 64'(bus.generation_o), 64'd0);
        check_eq("arst_cell", 64'(bus.rd_state_o), 64'd0);
        read_map(m);
        check_eq("arst_map", m, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("post_rst_busy", 64'(bus.busy_o), 64'd0);
        check_eq("post_rst_gen", 64'(bus.generation_o), 64'd0);
        read_map(m);
        check_eq("post_rst_map", m, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
